// File: rtl/alu_md_unit.sv
// alu_md_unit: iterative RV32M multiply/divide execution unit.
//   One result bit per cycle. Multiply uses a shift-add accumulator and
//   divide uses a restoring divider, both on unsigned magnitudes. A final FIX
//   cycle applies the result sign and selects the requested half or part.
//   Divide by zero and signed overflow finish one cycle after accept.
// Build option: define ALU_MD_DIV_EN to include the divider. When it is
//   undefined, funct3[2]=1 requests complete after one cycle with
//   o_illegal=1 and o_result=0.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_valid/o_ready  request handshake (accept = i_valid && o_ready)
//   i_funct3         M-extension op select
//   i_rs1, i_rs2     operands A and B
//   i_flush          abort an operation in progress
//   o_valid          one-cycle result strobe
//   o_result         result, held until the next completion
//   o_illegal        qualifies o_valid: op unsupported in this build
module alu_md_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   m_q;    // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0]   hi_q;   // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;   // multiplier, then product low / dividend, then quotient
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   res_q;
  logic              ill_q;

  logic            accept, is_div, sgn_a, sgn_b, div0, ovf, fast, fast_ill, neg_d;
  logic [XLEN-1:0] abs_a, abs_b, fast_res, fix_res, step_hi, step_lo;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] prod, prod_s;
`ifdef ALU_MD_DIV_EN
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] quo_s, rem_s;
`endif

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_result  = res_q;
  assign o_illegal = ill_q;

  // Accept-time decode: operand signs, magnitudes, result sign, fast path.
  always_comb begin
    accept = i_valid && (state_q == IDLE) && !i_flush;
    is_div = i_funct3[2];
    sgn_a  = (i_funct3 inside {3'b001, 3'b010, 3'b100, 3'b110}) && i_rs1[XLEN-1];
    sgn_b  = (i_funct3 inside {3'b001, 3'b100, 3'b110}) && i_rs2[XLEN-1];
    abs_a  = sgn_a ? -i_rs1 : i_rs1;
    abs_b  = sgn_b ? -i_rs2 : i_rs2;
    div0   = (i_rs2 == '0);
    ovf    = !i_funct3[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
    if (!is_div)          neg_d = sgn_a ^ sgn_b;
    else if (i_funct3[1]) neg_d = sgn_a;
    else                  neg_d = (sgn_a ^ sgn_b) && !div0;
`ifdef ALU_MD_DIV_EN
    fast     = is_div && (div0 || ovf);
    fast_ill = 1'b0;
    if (div0)             fast_res = i_funct3[1] ? i_rs1 : '1;
    else                  fast_res = i_funct3[1] ? '0 : i_rs1;
`else
    fast     = is_div;
    fast_ill = 1'b1;
    fast_res = '0;
`endif
  end

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_MD_DIV_EN
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, m_q};
    if (f3_q[2]) begin
      // Partial remainder stays below the divisor, so the shifted value fits
      // in XLEN+1 bits and div_diff[XLEN] is the borrow.
      step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], !div_diff[XLEN]};
    end
`endif
  end

  // Sign fix-up and result selection.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
`ifdef ALU_MD_DIV_EN
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = neg_q ? -hi_q : hi_q;
    case (f3_q)
      3'b000:                   fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:           fix_res = quo_s;
      default:                  fix_res = rem_s;
    endcase
`else
    case (f3_q)
      3'b000:                   fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   fix_res = prod_s[2*XLEN-1:XLEN];
      default:                  fix_res = '0;
    endcase
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: begin
        if (i_flush)                                state_d = IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))         state_d = FIX;
      end
      FIX:  state_d = i_flush ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f3_q  <= '0;
      neg_q <= 1'b0;
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          f3_q  <= i_funct3;
          neg_q <= neg_d;
          cnt_q <= '0;
          hi_q  <= '0;
          lo_q  <= is_div ? abs_a : abs_b;
          m_q   <= is_div ? abs_b : abs_a;
          if (fast) begin
            res_q <= fast_res;
            ill_q <= fast_ill;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          hi_q  <= step_hi;
          lo_q  <= step_lo;
        end
        FIX: if (!i_flush) begin
          res_q <= fix_res;
          ill_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: directed self-checking bench for alu_md_unit (XLEN=32).
//   Expected values are hand-computed constants. The divide vectors are
//   selected by ALU_MD_DIV_EN, matching the build of the unit under test.
module tb_alu_md_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_illegal;

  int n_checks = 0;
  int n_err    = 0;

  always #5 i_clk = ~i_clk;

  alu_md_unit #(.XLEN(32)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_funct3  (i_funct3),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .o_result  (o_result),
    .o_illegal (o_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next negedge (caller leaves the unit idle), then
  // scramble the inputs and wait for the strobe. Latency counts cycles from
  // the accept edge up to and including the o_valid cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int lat;
    int busy;
    @(negedge i_clk);
    check({tag, " ready"}, 32'(o_ready), 32'd1);
    i_valid  = 1'b1;
    i_funct3 = f3;
    i_rs1    = a;
    i_rs2    = b;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_funct3 = 3'($urandom);
    i_rs1    = $urandom;
    i_rs2    = $urandom;
    lat  = 1;
    busy = 0;
    while (!o_valid && lat < 100) begin
      if (!o_ready) busy++;
      @(posedge i_clk);
      #1;
      lat++;
    end
    if (!o_ready) busy++;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, 32'(busy), 32'(exp_lat));
    check({tag, " result"}, o_result, exp_res);
    check({tag, " illegal"}, 32'(o_illegal), 32'(exp_ill));
    @(posedge i_clk);
    #1;
    check({tag, " strobe_len"}, 32'(o_valid), 32'd0);
    check({tag, " hold"}, o_result, exp_res);
  endtask

  initial begin
    int seen;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_funct3 = 3'd0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_flush  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst ready", 32'(o_ready), 32'd1);
    check("rst valid", 32'(o_valid), 32'd0);
    check("rst result", o_result, 32'd0);
    check("rst illegal", 32'(o_illegal), 32'd0);
    i_rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 34);
`ifdef ALU_MD_DIV_EN
    run_op("div0",   3'b100, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 1'b0, 1);
    run_op("remu0",  3'b111, 32'd5,        32'd0,         32'd5,         1'b0, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 34);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 34);
    run_op("divu",   3'b101, 32'd100,      32'd7,         32'd14,        1'b0, 34);
    run_op("remu",   3'b111, 32'd100,      32'd7,         32'd2,         1'b0, 34);
`else
    run_op("div_ill",  3'b100, 32'd10,  32'd2, 32'd0,  1'b1, 1);
    run_op("remu_ill", 3'b111, 32'd100, 32'd7, 32'd0,  1'b1, 1);
    run_op("mul34",    3'b000, 32'd3,   32'd4, 32'd12, 1'b0, 34);
`endif
    run_op("mul35", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 34);

    // Flush while idle with a request present: nothing is accepted.
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_flush  = 1'b1;
    i_funct3 = 3'b000;
    i_rs1    = 32'd9;
    i_rs2    = 32'd9;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("idleflush ready", 32'(o_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    check("idleflush novalid", 32'(seen), 32'd0);
    check("idleflush result", o_result, 32'd15);

    // Flush mid-CALC: abort, no strobe, previous result retained.
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_funct3 = 3'b011;
    i_rs1    = 32'hFFFF_FFFF;
    i_rs2    = 32'hFFFF_FFFF;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    check("flush ready", 32'(o_ready), 32'd1);
    check("flush valid", 32'(o_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    check("flush novalid", 32'(seen), 32'd0);
    check("flush result", o_result, 32'd15);

    // Reset mid-CALC: outputs return to reset values one cycle later.
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_funct3 = 3'b000;
    i_rs1    = 32'd6;
    i_rs2    = 32'd7;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midrst ready", 32'(o_ready), 32'd1);
    check("midrst valid", 32'(o_valid), 32'd0);
    check("midrst result", o_result, 32'd0);
    check("midrst illegal", 32'(o_illegal), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    check("midrst novalid", 32'(seen), 32'd0);

    run_op("postrst", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Iterative RV32M multiply/divide execution unit, parametrised in datapath width, and the multi-cycle companion to the single-cycle ALU control path. Decodes the M-extension `funct3` itself and runs a one-bit-per-cycle shift-add multiplier or restoring divider. Sits beside the ALU in execute; the core stalls on `o_ready` low and takes the result on the single-cycle `o_valid` pulse.

## Interface
- `XLEN`, default 32: operand/result width, ≥ 8 and even.
- `CNT_W`, default `$clog2(XLEN)+1`: width of the iteration counter.
- `i_clk` input 1: clock, all logic on rising edge.
- `i_rst` input 1: reset, synchronous and active-high.
- `i_valid` input 1: request present.
- `o_ready` output 1: unit idle; request accepted when `i_valid && o_ready`.
- `i_funct3` input 3: decoding as follows.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_rs1` input XLEN: operand A (dividend / multiplicand).
- `i_rs2` input XLEN: operand B (divisor / multiplier).
- `i_flush` input 1: abort any operation in progress.
- `o_valid` output 1: one-cycle result strobe.
- `o_result` output XLEN: result, held until next accept.
- `o_illegal` output 1: qualifies `o_valid`; op not supported in this build.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. `o_ready` = (state == IDLE).
- **IDLE, on accept:** latch funct3, operand signs, and |A|, |B|.
  - Signed only where the op requires it. MULHSU: A signed, B unsigned.
  - Result sign is computed and latched at accept:
    - MUL*: sign(A) xor sign(B).
    - DIV: sign(A) xor sign(B), forced positive on divide by zero.
    - REM: sign(A).
- **Fast path (IDLE→DONE, no CALC):**
  - Divide by zero: DIV/DIVU quotient is all ones; REM/REMU returns A.
  - Signed overflow (A = −2^(XLEN−1), B = −1): DIV returns A; REM returns 0.
- **CALC:** XLEN iterations, counter from 0 to XLEN−1.
  - Multiply: 2·XLEN-bit unsigned shift-add accumulator.
  - Divide: restoring algorithm on unsigned magnitudes.
- **FIX:** one cycle.
  - Two's-complement negate of the 2·XLEN product or of the quotient/remainder when the result sign is negative.
  - Select the output: low half (MUL), high half (MULH*), quotient, or remainder.
- **DONE:** `o_valid`=1 for exactly one cycle, then IDLE.
- `o_result` and `o_illegal` update only on entry to DONE and hold afterwards.
- **`i_flush`:**
  - In CALC or FIX: go to IDLE with no `o_valid`; `o_result` is unchanged.
  - In DONE: `o_valid` still fires this cycle (completed work).
  - In IDLE with `i_valid`: flush wins and the request is not accepted.
- **Reset:** state IDLE, `o_ready`=1, `o_valid`=0, `o_result`=0, `o_illegal`=0, counter 0, all datapath registers 0. Reset mid-CALC aborts with no strobe.
- **Input stability:** inputs are sampled only at accept; later changes are ignored.

## Timing
- Accept at edge 0.
- Normal ops: CALC occupies edges 1..XLEN and FIX occupies edge XLEN+1. `o_valid` is high in the cycle after edge XLEN+1, i.e. latency XLEN+2 cycles (34 at XLEN=32).
- Fast path: `o_valid` in the cycle after the accept edge (latency 1).
- Back-to-back: the next accept is possible at the edge ending the DONE cycle + 1. `o_ready` rises the cycle after `o_valid`.
- No output backpressure; the consumer must take the result on the strobe.

## Configuration
- `ALU_MD_DIV_EN` defined: full RV32M as above.
- Undefined:
  - Divider datapath is removed.
  - funct3[2]=1 requests take the fast path and complete with latency 1, `o_valid`=1, `o_illegal`=1, `o_result`=0.
  - Multiply is unaffected.

## Test plan
- MUL, A=7, B=0xFFFFFFFD → `o_result`=0xFFFFFFEB, `o_valid` exactly 34 cycles after accept, `o_ready` low for 34 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0x12345678/0 → 0xFFFFFFFF in 1 cycle; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Issue each back-to-back at the earliest `o_ready`.
- `i_flush` pulse at cycle 10 of CALC → no `o_valid`, `o_ready` high the next cycle, prior `o_result` retained. `i_rst` mid-CALC → all outputs at reset values one cycle later.
- Build without `ALU_MD_DIV_EN`: DIV 10/2 → `o_valid`+`o_illegal` after 1 cycle, `o_result`=0. MUL 3×4 → 12 with `o_illegal`=0.
